// File: rtl/ff_shreg.sv
// ff_shreg -- parametrised multi-stage register bank.
//
// DEPTH stages of WIDTH bits each, with clock enable, synchronous reset and
// four operating modes.
// Usable as a delay line, a serial-to-parallel buffer or a parallel-to-serial buffer.
//
// Parameters:
//   WIDTH      bits per stage (>= 1)
//   DEPTH      number of stages (>= 1); DEPTH=1 is a plain enabled register
//   RESET_VAL  value loaded into every stage on reset
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset (overrides clk_en and mode)
//   clk_en  clock enable; 0 freezes all state
//   mode    00 HOLD, 01 SHIFT, 10 LOAD, 11 ROTATE
//   d       serial word shifted into stage 0
//   par_d   parallel load data, stage i = par_d[i*WIDTH +: WIDTH]
//   q       contents of stage DEPTH-1
//   par_q   all stages, same packing as par_d
//   fill    number of stages written since reset, 0..DEPTH
//   full    fill == DEPTH
module ff_shreg #(
    parameter int                WIDTH     = 8,
    parameter int                DEPTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    localparam int               FW        = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic [1:0]               mode,
    input  logic [WIDTH-1:0]         d,
    input  logic [WIDTH*DEPTH-1:0]   par_d,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH*DEPTH-1:0]   par_q,
    output logic [FW-1:0]            fill,
    output logic                     full
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_LOAD   = 2'b10,
        MODE_ROTATE = 2'b11
    } mode_t;

    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    logic [WIDTH-1:0] s      [DEPTH];
    logic [WIDTH-1:0] s_next [DEPTH];
    logic [FW-1:0]    fill_r;
    logic [FW-1:0]    fill_next;
    mode_t            mode_sel;

    assign mode_sel = mode_t'(mode);

    // Next-state selection for the stage array and fill counter.
    // The enable and reset are applied in the register block so that this
    // block only describes what each mode does.
    always_comb begin
        s_next    = s;
        fill_next = fill_r;
        case (mode_sel)
            MODE_SHIFT: begin
                s_next[0] = d;
                for (int i = 1; i < DEPTH; i++) begin
                    s_next[i] = s[i-1];
                end
                // Saturate: once every stage is written, further shifts
                // only push the oldest word off the end.
                if (fill_r != FILL_MAX) begin
                    fill_next = fill_r + 1'b1;
                end
            end
            MODE_LOAD: begin
                for (int i = 0; i < DEPTH; i++) begin
                    s_next[i] = par_d[i*WIDTH +: WIDTH];
                end
                fill_next = FILL_MAX;
            end
            MODE_ROTATE: begin
                // With DEPTH=1 this writes s[0] back to itself, i.e. HOLD.
                s_next[0] = s[DEPTH-1];
                for (int i = 1; i < DEPTH; i++) begin
                    s_next[i] = s[i-1];
                end
            end
            default: begin
                // HOLD: defaults already keep the current state.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                s[i] <= RESET_VAL;
            end
            fill_r <= '0;
        end else if (clk_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                s[i] <= s_next[i];
            end
            fill_r <= fill_next;
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_pack
            assign par_q[g*WIDTH +: WIDTH] = s[g];
        end
    endgenerate

    assign q    = s[DEPTH-1];
    assign fill = fill_r;
    // Derived from the fill register, so it changes only on clk.
    assign full = (fill_r == FILL_MAX);

endmodule

// File: tb/tb_ff_shreg.sv
// tb_ff_shreg -- randomized bench for ff_shreg against a queue-based model.
//
// Main instance: WIDTH=4, DEPTH=3, RESET_VAL=0. A second instance with
// WIDTH=1, DEPTH=1, RESET_VAL=1 covers the single-flop corner.
module tb_ff_shreg;

  localparam int W  = 4;
  localparam int D  = 3;
  localparam logic [W-1:0] RV = 4'h0;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           clk_en;
  logic [1:0]     mode;
  logic [W-1:0]   d;
  logic [W*D-1:0] par_d;
  logic [W-1:0]   q;
  logic [W*D-1:0] par_q;
  logic [1:0]     fill;
  logic           full;

  logic       rst1;
  logic       clk_en1;
  logic [1:0] mode1;
  logic       d1;
  logic       par_d1;
  logic       q1;
  logic       par_q1;
  logic       fill1;
  logic       full1;

  ff_shreg #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .mode(mode), .d(d),
    .par_d(par_d), .q(q), .par_q(par_q), .fill(fill), .full(full)
  );

  ff_shreg #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .clk_en(clk_en1), .mode(mode1), .d(d1),
    .par_d(par_d1), .q(q1), .par_q(par_q1), .fill(fill1), .full(full1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: a queue of words, element 0 is stage 0 (newest).
  logic [W-1:0] mw[$];
  int           mfill;
  bit           mvalid = 1'b0;

  function automatic logic [W*D-1:0] model_par();
    logic [W*D-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) r[i*W +: W] = mw[i];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mw.delete();
      for (int i = 0; i < D; i++) mw.push_back(RV);
      mfill  = 0;
      mvalid = 1'b1;
    end else if (mvalid && clk_en) begin
      case (mode)
        2'b01: begin
          mw.push_front(d);
          void'(mw.pop_back());
          if (mfill < D) mfill++;
        end
        2'b10: begin
          for (int i = 0; i < D; i++) mw[i] = par_d[i*W +: W];
          mfill = D;
        end
        2'b11: begin
          logic [W-1:0] last;
          last = mw.pop_back();
          mw.push_front(last);
        end
        default: ;
      endcase
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_par_q", 32'(par_q), 32'(model_par()));
      chk("model_q",     32'(q),     32'(mw[D-1]));
      chk("model_fill",  32'(fill),  32'(mfill));
      chk("model_full",  32'(full),  32'(mfill == D));
    end
  end

  // driver tasks: each call applies exactly one rising edge
  task automatic drive(input logic r, input logic en, input logic [1:0] m,
                       input logic [W-1:0] dd, input logic [W*D-1:0] pd);
    @(negedge clk);
    rst = r; clk_en = en; mode = m; d = dd; par_d = pd;
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic r, input logic en, input logic [1:0] m, input logic dd);
    @(negedge clk);
    rst1 = r; clk_en1 = en; mode1 = m; d1 = dd; par_d1 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [W*D-1:0] pq, input int fl);
    chk({name, "_par_q"}, 32'(par_q), 32'(pq));
    chk({name, "_fill"},  32'(fill),  32'(fl));
    chk({name, "_full"},  32'(full),  32'(fl == D));
  endtask

  initial begin
    rst = 1'b0; clk_en = 1'b0; mode = 2'b00; d = '0; par_d = '0;
    rst1 = 1'b0; clk_en1 = 1'b0; mode1 = 2'b00; d1 = 1'b0; par_d1 = 1'b0;

    // reset overrides enable and mode
    drive(1'b1, 1'b0, 2'b01, 4'hF, '0);
    lit("reset", 12'h000, 0);
    chk("reset_q", 32'(q), 32'h0);

    // plain shift stream
    drive(1'b0, 1'b1, 2'b01, 4'h1, '0);
    drive(1'b0, 1'b1, 2'b01, 4'h2, '0);
    drive(1'b0, 1'b1, 2'b01, 4'h3, '0);
    lit("shift3", 12'h123, 3);
    drive(1'b0, 1'b1, 2'b01, 4'h4, '0);
    lit("shift4", 12'h234, 3);
    chk("shift4_q", 32'(q), 32'h2);

    // same stream with an enable gap
    drive(1'b1, 1'b1, 2'b00, 4'h0, '0);
    drive(1'b0, 1'b1, 2'b01, 4'h1, '0);
    drive(1'b0, 1'b0, 2'b01, 4'h9, '0);
    lit("gap", 12'h001, 1);
    drive(1'b0, 1'b1, 2'b01, 4'h2, '0);
    drive(1'b0, 1'b1, 2'b01, 4'h3, '0);
    drive(1'b0, 1'b1, 2'b01, 4'h4, '0);
    lit("gap_end", 12'h234, 3);

    // load then rotate
    drive(1'b1, 1'b1, 2'b00, 4'h0, '0);
    drive(1'b0, 1'b1, 2'b10, 4'h0, 12'hABC);
    lit("load", 12'hABC, 3);
    chk("load_q", 32'(q), 32'hA);
    drive(1'b0, 1'b1, 2'b11, 4'h0, '0);
    lit("rot1", 12'hBCA, 3);
    drive(1'b0, 1'b1, 2'b11, 4'h0, '0);
    lit("rot2", 12'hCAB, 3);
    drive(1'b0, 1'b1, 2'b11, 4'h0, '0);
    lit("rot3", 12'hABC, 3);

    // reset mid-stream
    drive(1'b0, 1'b1, 2'b01, 4'h5, '0);
    drive(1'b0, 1'b1, 2'b01, 4'h6, '0);
    drive(1'b1, 1'b1, 2'b01, 4'h8, '0);
    lit("midrst", 12'h000, 0);
    drive(1'b0, 1'b1, 2'b01, 4'h7, '0);
    lit("after_rst", 12'h007, 1);

    // single-flop instance
    drive1(1'b1, 1'b0, 2'b01, 1'b0);
    chk("d1_reset_q", 32'(q1), 32'h1);
    chk("d1_reset_fill", 32'(fill1), 32'h0);
    drive1(1'b0, 1'b1, 2'b01, 1'b0);
    chk("d1_shift_q", 32'(q1), 32'h0);
    chk("d1_shift_full", 32'(full1), 32'h1);
    drive1(1'b0, 1'b0, 2'b01, 1'b1);
    chk("d1_hold_q", 32'(q1), 32'h0);
    drive1(1'b0, 1'b1, 2'b11, 1'b1);
    chk("d1_rotate_q", 32'(q1), 32'h0);
    drive1(1'b0, 1'b1, 2'b10, 1'b1);
    chk("d1_load_q", 32'(q1), 32'h0);

    // randomized phase, checked by the compare process
    for (int n = 0; n < 500; n++) begin
      drive(($urandom_range(0, 40) == 0),
            ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)),
            W'($urandom),
            (W*D)'($urandom));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
